// File: rtl/ic_hc_coef_serializer.sv
// Coefficient-vector serializer with per-channel DC differencing.
// Each accepted vector is emitted one coefficient per output transfer.
module ic_hc_coef_serializer #(
    parameter int  COEF_W   = 13,
    parameter int  NUM_COEF = 8,
    parameter int  NUM_CH   = 3,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_COEF*COEF_W-1:0] in_data,
    input  logic                       in_dc,
    input  logic [CH_W-1:0]            in_ch,
    input  logic                       pred_clr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [COEF_W-1:0]          writedata,
    output logic                       out_first,
    output logic                       out_last,
    output logic [CH_W-1:0]            out_ch
);

    localparam int IDX_W = (NUM_COEF > 1) ? $clog2(NUM_COEF) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEF - 1);

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [COEF_W-1:0]   r_coef [NUM_COEF];
    logic [COEF_W-1:0]   r_pred [NUM_CH];
    logic [COEF_W-1:0]   r_wd;
    logic                r_valid;
    logic                r_first;
    logic                r_last;
    logic [CH_W-1:0]     r_ch;

    logic                w_is_last;
    logic                w_in_xfer;
    logic                w_out_xfer;
    logic                w_ch_ok;
    logic                w_dc_en;
    logic [COEF_W-1:0]   w_pred;
    logic [COEF_W-1:0]   w_coef0;
    logic [COEF_W-1:0]   w_in_coef [NUM_COEF];
    logic [IDX_W-1:0]    w_idx_nxt;

    assign w_is_last  = (r_state == ST_SHIFT) && (r_idx == LAST_IDX);
    assign in_ready   = !reset && ((r_state == ST_IDLE) || (w_is_last && out_ready));
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = (r_state == ST_SHIFT) && out_ready;
    assign w_idx_nxt  = r_idx + IDX_W'(1);

    // Channel decode doubles as the range check: an out-of-range in_ch matches nothing.
    always_comb begin
        w_ch_ok = 1'b0;
        w_pred  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (in_ch == CH_W'(c)) begin
                w_ch_ok = 1'b1;
                w_pred  = r_pred[c];
            end
        end
        if (pred_clr)
            w_pred = '0;
    end

    assign w_dc_en = in_dc && w_ch_ok;
    assign w_coef0 = w_dc_en ? (in_data[COEF_W-1:0] - w_pred) : in_data[COEF_W-1:0];

    always_comb begin
        for (int k = 0; k < NUM_COEF; k++)
            w_in_coef[k] = in_data[k*COEF_W +: COEF_W];
        w_in_coef[0] = w_coef0;
    end

    // Predictor update for the accepted channel takes priority over a coincident clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++)
                r_pred[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_in_xfer && w_dc_en && (in_ch == CH_W'(c)))
                    r_pred[c] <= in_data[COEF_W-1:0];
                else if (pred_clr)
                    r_pred[c] <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_wd    <= '0;
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            r_ch    <= '0;
        end else if (w_in_xfer) begin
            r_state <= ST_SHIFT;
            r_idx   <= '0;
            r_coef  <= w_in_coef;
            r_wd    <= w_coef0;
            r_valid <= 1'b1;
            r_first <= 1'b1;
            r_last  <= 1'b0;
            r_ch    <= in_ch;
        end else if (w_out_xfer) begin
            if (w_is_last) begin
                r_state <= ST_IDLE;
                r_idx   <= '0;
                r_valid <= 1'b0;
                r_first <= 1'b0;
                r_last  <= 1'b0;
            end else begin
                r_idx   <= w_idx_nxt;
                r_wd    <= r_coef[w_idx_nxt];
                r_first <= 1'b0;
                r_last  <= (w_idx_nxt == LAST_IDX);
            end
        end
    end

    assign out_valid = r_valid;
    assign writedata = r_wd;
    assign out_first = r_first;
    assign out_last  = r_last;
    assign out_ch    = r_ch;

endmodule

// File: tb/tb_ic_hc_coef_serializer.sv
// Directed bench for ic_hc_coef_serializer: DC differencing, streaming, stalls, reset.
module tb_ic_hc_coef_serializer;

    localparam int W = 13;
    localparam int N = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_data;
    logic           in_dc;
    logic [1:0]     in_ch;
    logic           pred_clr;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   writedata;
    logic           out_first;
    logic           out_last;
    logic [1:0]     out_ch;

    int n_vec = 0;
    int n_err = 0;

    ic_hc_coef_serializer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_dc(in_dc), .in_ch(in_ch), .pred_clr(pred_clr),
        .out_valid(out_valid), .out_ready(out_ready), .writedata(writedata),
        .out_first(out_first), .out_last(out_last), .out_ch(out_ch)
    );

    always #5 clk = ~clk;

    function automatic logic [N*W-1:0] mkvec(input logic [W-1:0] c0);
        logic [N*W-1:0] v;
        v = '0;
        v[W-1:0] = c0;
        for (int k = 1; k < N; k++) v[k*W +: W] = W'(k);
        return v;
    endfunction

    // Drives one vector from idle and drains it; returns what appeared on the first beat.
    task automatic xfer_vec(input logic [W-1:0] c0, input logic dc, input logic [1:0] ch,
                            input logic clr, output logic [W-1:0] wd0,
                            output logic [1:0] ch0, output logic f0);
        @(negedge clk);
        in_valid = 1'b1; in_data = mkvec(c0); in_dc = dc; in_ch = ch; pred_clr = clr;
        @(negedge clk);
        in_valid = 1'b0; pred_clr = 1'b0;
        wd0 = writedata; ch0 = out_ch; f0 = out_first;
        repeat (N - 1) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_dc = 1'b0; in_ch = '0;
        pred_clr = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_vec++; if (writedata !== '0) begin n_err++; $display("FAIL rst_writedata: got %0h want 0", writedata); end
        n_vec++; if ({out_first, out_last, out_ch} !== 4'b0) begin n_err++; $display("FAIL rst_flags: got %b want 0000", {out_first, out_last, out_ch}); end
        reset = 1'b0;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic;
        @(negedge clk);
        in_valid = 1'b1; in_data = mkvec(13'd100); in_dc = 1'b1; in_ch = 2'd0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (k > 0) @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b1 || writedata !== (k == 0 ? W'(100) : W'(k)) ||
                out_first !== (k == 0) || out_last !== (k == N - 1) || out_ch !== 2'd0) begin
                n_err++;
                $display("FAIL basic_beat%0d: got v=%b d=%0d f=%b l=%b ch=%0d want v=1 d=%0d f=%b l=%b ch=0",
                         k, out_valid, writedata, out_first, out_last, out_ch,
                         (k == 0 ? 100 : k), (k == 0), (k == N - 1));
            end
        end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin n_err++; $display("FAIL basic_idle: got v=%b l=%b want 0 0", out_valid, out_last); end
    endtask

    task automatic test_dc_diff;
        logic [W-1:0] wd; logic [1:0] ch; logic f;
        xfer_vec(13'd90, 1'b1, 2'd0, 1'b0, wd, ch, f);
        n_vec++; if (wd !== 13'h1FF6 || f !== 1'b1) begin n_err++; $display("FAIL dc_ch0_neg: got %0h f=%b want 1ff6 f=1", wd, f); end
        xfer_vec(13'd50, 1'b1, 2'd1, 1'b0, wd, ch, f);
        n_vec++; if (wd !== 13'd50 || ch !== 2'd1) begin n_err++; $display("FAIL dc_ch1_indep: got %0d ch=%0d want 50 ch=1", wd, ch); end
        xfer_vec(13'd77, 1'b1, 2'd3, 1'b0, wd, ch, f);
        n_vec++; if (wd !== 13'd77 || ch !== 2'd3) begin n_err++; $display("FAIL dc_ch_oor: got %0d ch=%0d want 77 ch=3", wd, ch); end
        xfer_vec(13'd40, 1'b0, 2'd0, 1'b0, wd, ch, f);
        n_vec++; if (wd !== 13'd40) begin n_err++; $display("FAIL dc_off: got %0d want 40", wd); end
        xfer_vec(13'd95, 1'b1, 2'd0, 1'b0, wd, ch, f);
        n_vec++; if (wd !== 13'd5) begin n_err++; $display("FAIL dc_pred_kept: got %0d want 5", wd); end
        xfer_vec(13'd20, 1'b1, 2'd1, 1'b0, wd, ch, f);
        n_vec++; if (wd !== 13'h1FE2) begin n_err++; $display("FAIL dc_ch1_neg: got %0h want 1fe2", wd); end
    endtask

    task automatic test_pred_clr;
        logic [W-1:0] wd; logic [1:0] ch; logic f;
        xfer_vec(13'd100, 1'b1, 2'd0, 1'b0, wd, ch, f);
        n_vec++; if (wd !== 13'd5) begin n_err++; $display("FAIL clr_pre: got %0d want 5", wd); end
        @(negedge clk); pred_clr = 1'b1;
        @(negedge clk); pred_clr = 1'b0;
        xfer_vec(13'd100, 1'b1, 2'd0, 1'b0, wd, ch, f);
        n_vec++; if (wd !== 13'd100) begin n_err++; $display("FAIL clr_between: got %0d want 100", wd); end
        xfer_vec(13'd60, 1'b1, 2'd0, 1'b1, wd, ch, f);
        n_vec++; if (wd !== 13'd60) begin n_err++; $display("FAIL clr_coincident: got %0d want 60", wd); end
        xfer_vec(13'd70, 1'b1, 2'd0, 1'b0, wd, ch, f);
        n_vec++; if (wd !== 13'd10) begin n_err++; $display("FAIL clr_update_wins: got %0d want 10", wd); end
        xfer_vec(13'd25, 1'b1, 2'd1, 1'b0, wd, ch, f);
        n_vec++; if (wd !== 13'd25) begin n_err++; $display("FAIL clr_all_ch: got %0d want 25", wd); end
    endtask

    task automatic test_back_to_back;
        int j;
        @(negedge clk);
        in_valid = 1'b1; in_dc = 1'b1; in_ch = 2'd2; in_data = mkvec(13'd10);
        j = 0;
        for (int t = 0; t < 3 * N; t++) begin
            @(negedge clk);
            if (t % N == 0) begin
                j = t / N;
                if (j < 2) in_data = mkvec(W'(10 * (j + 2)));
                else in_valid = 1'b0;
            end
            #1;
            n_vec++;
            if (out_valid !== 1'b1 || writedata !== (t % N == 0 ? W'(10) : W'(t % N)) ||
                in_ready !== (t % N == N - 1)) begin
                n_err++;
                $display("FAIL b2b_t%0d: got v=%b d=%0d rdy=%b want v=1 d=%0d rdy=%b",
                         t, out_valid, writedata, in_ready, (t % N == 0 ? 10 : t % N), (t % N == N - 1));
            end
        end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end: got v=%b want 0", out_valid); end
    endtask

    task automatic test_stall;
        logic [31:0] pat;
        int pos;
        pat = 32'b1011_0010_1101_0011_0110_1001_1100_0101;
        pos = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = mkvec(13'd75); in_dc = 1'b1; in_ch = 2'd0; out_ready = 1'b0;
        for (int c = 0; c < 32 && pos < N; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            n_vec++;
            if (out_valid !== 1'b1 || writedata !== (pos == 0 ? W'(5) : W'(pos)) ||
                out_first !== (pos == 0) || out_last !== (pos == N - 1)) begin
                n_err++;
                $display("FAIL stall_c%0d: got v=%b d=%0d f=%b l=%b want v=1 d=%0d f=%b l=%b",
                         c, out_valid, writedata, out_first, out_last,
                         (pos == 0 ? 5 : pos), (pos == 0), (pos == N - 1));
            end
            out_ready = pat[c];
            if (pat[c]) pos++;
        end
        n_vec++; if (pos !== N) begin n_err++; $display("FAIL stall_budget: got %0d beats want %0d", pos, N); end
        @(negedge clk);
        out_ready = 1'b1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_count: got v=%b want 0", out_valid); end
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] wd; logic [1:0] ch; logic f;
        @(negedge clk);
        in_valid = 1'b1; in_data = mkvec(13'd200); in_dc = 1'b1; in_ch = 2'd0;
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++; if (writedata !== 13'd125) begin n_err++; $display("FAIL rmid_first: got %0d want 125", writedata); end
        repeat (3) @(negedge clk);
        n_vec++; if (writedata !== 13'd3) begin n_err++; $display("FAIL rmid_idx3: got %0d want 3", writedata); end
        reset = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rmid_rdy_in_rst: got %b want 0", in_ready); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0 || writedata !== '0 || out_first !== 1'b0) begin
            n_err++; $display("FAIL rmid_cleared: got v=%b d=%0d f=%b want 0 0 0", out_valid, writedata, out_first);
        end
        reset = 1'b0;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rmid_rdy_after: got %b want 1", in_ready); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_no_partial: got v=%b want 0", out_valid); end
        xfer_vec(13'd123, 1'b1, 2'd0, 1'b0, wd, ch, f);
        n_vec++; if (wd !== 13'd123 || f !== 1'b1) begin n_err++; $display("FAIL rmid_pred_zero: got %0d f=%b want 123 f=1", wd, f); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_dc_diff;
        test_pred_clr;
        test_back_to_back;
        test_stall;
        test_reset_mid;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
